// File: rtl/ps2_scan_ctrl.sv
// PS/2 Set 2 scan-code sequencer: folds E0/F0 prefixes into complete key
// events, queues them in a small FWFT FIFO, and tracks the last two codes,
// a sticky overflow flag and a saturating error count.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   IDLE     | no prefix pending, next byte starts an event
//   GOT_E0   | extended prefix seen
//   GOT_F0   | release prefix seen
//   GOT_E0F0 | extended release prefix seen
module ps2_scan_ctrl #(
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic               clk_50,
    input  logic               rst_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               rx_err,
    input  logic               clr,
    input  logic               ev_ready,
    output logic               ev_valid,
    output logic [7:0]         ev_code,
    output logic               ev_ext,
    output logic               ev_break,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic [7:0]         err_cnt,
    output logic [7:0]         last_code,
    output logic [7:0]         prev_code
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t               state;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 is_e0, is_f0, is_resp;
    logic                 ev_done, proto_err, tmo_hit, err_inc;
    logic                 new_ext, new_brk;
    logic                 push, pop, full;
    logic [9:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;

    // Byte classification, event completion and error sources for this cycle
    always_comb begin
        is_e0     = (rx_data == 8'hE0);
        is_f0     = (rx_data == 8'hF0);
        is_resp   = (rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF});
        ev_done   = 1'b0;
        proto_err = 1'b0;
        if (rx_valid && !rx_err) begin
            case (state)
                IDLE: ev_done = !is_e0 && !is_f0 && !is_resp;
                GOT_E0: begin
                    proto_err = is_e0;
                    ev_done   = !is_e0 && !is_f0;
                end
                default: begin
                    proto_err = is_e0 || is_f0;
                    ev_done   = !is_e0 && !is_f0;
                end
            endcase
        end
        tmo_hit = !rx_valid && (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
        err_inc = (rx_valid && rx_err) || proto_err || tmo_hit;
        new_ext = (state == GOT_E0) || (state == GOT_E0F0);
        new_brk = (state == GOT_F0) || (state == GOT_E0F0);
        full    = (fifo_level == (FIFO_AW + 1)'(DEPTH));
        pop     = ev_valid && ev_ready;
        push    = ev_done && (!full || pop);
    end

    // Prefix parser with inter-byte timeout
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            if (rx_valid) begin
                if (rx_err) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE:    state <= is_e0 ? GOT_E0 : (is_f0 ? GOT_F0 : IDLE);
                        GOT_E0:  state <= is_f0 ? GOT_E0F0 : IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end else if (tmo_hit) begin
                state <= IDLE;
            end
            if (rx_valid || (state == IDLE) || tmo_hit)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Status: error count, sticky overflow, display history; clr beats same-cycle events
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            overflow  <= 1'b0;
            last_code <= '0;
            prev_code <= '0;
        end else begin
            if (clr) begin
                err_cnt  <= '0;
                overflow <= 1'b0;
            end else begin
                if (err_inc && (err_cnt != 8'hFF))
                    err_cnt <= err_cnt + 8'd1;
                if (ev_done && !push)
                    overflow <= 1'b1;
            end
            if (ev_done) begin
                last_code <= rx_data;
                prev_code <= last_code;
            end
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && !pop)
                fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
            else if (pop && !push)
                fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
        end
    end

    // FIFO storage; entries are only observed through the valid-gated head
    always_ff @(posedge clk_50) begin
        if (push)
            mem[wr_ptr] <= {new_brk, new_ext, rx_data};
    end

    assign ev_valid = (fifo_level != '0);
    assign {ev_break, ev_ext, ev_code} = ev_valid ? mem[rd_ptr] : 10'd0;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: prefix-flag reference model with a queue-based
// FIFO, checked every cycle, plus directed scenarios with literal results.
module tb_ps2_scan_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_err = 1'b0;
    logic       clr = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_break, overflow;
    logic [7:0] ev_code, err_cnt, last_code, prev_code;
    logic [AW:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_scan_ctrl #(.FIFO_AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_err(rx_err), .clr(clr), .ev_ready(ev_ready), .ev_valid(ev_valid),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .fifo_level(fifo_level), .overflow(overflow), .err_cnt(err_cnt),
        .last_code(last_code), .prev_code(prev_code)
    );

    always #10 clk_50 = ~clk_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t         mq[$];
    bit          pfx_ext, pfx_brk;
    int unsigned cyc = 0;
    int unsigned deadline = 0;
    int          m_err = 0;
    bit          m_ovf = 1'b0;
    logic [7:0]  m_last = 8'h00, m_prev = 8'h00;
    bit          m_got, m_bad, m_pop;
    int          m_sz;
    ev_t         m_ev;

    function automatic bit is_resp(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    // Model: a pending prefix is a pair of flags with a deadline in cycles
    always @(posedge clk_50) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
            pfx_ext = 1'b0; pfx_brk = 1'b0;
            m_err = 0; m_ovf = 1'b0; m_last = 8'h00; m_prev = 8'h00;
        end else begin
            m_got = 1'b0;
            m_bad = 1'b0;
            m_sz  = mq.size();
            m_pop = (m_sz != 0) && ev_ready;
            if (rx_valid) begin
                if (rx_err) begin
                    m_bad = 1'b1; pfx_ext = 1'b0; pfx_brk = 1'b0;
                end else if (rx_data == 8'hE0) begin
                    if (pfx_ext || pfx_brk) begin
                        m_bad = 1'b1; pfx_ext = 1'b0; pfx_brk = 1'b0;
                    end else begin
                        pfx_ext = 1'b1; deadline = cyc + TMO;
                    end
                end else if (rx_data == 8'hF0) begin
                    if (pfx_brk) begin
                        m_bad = 1'b1; pfx_ext = 1'b0; pfx_brk = 1'b0;
                    end else begin
                        pfx_brk = 1'b1; deadline = cyc + TMO;
                    end
                end else if (!(pfx_ext || pfx_brk) && is_resp(rx_data)) begin
                    m_got = 1'b0;
                end else begin
                    m_got = 1'b1;
                    m_ev  = '{code: rx_data, ext: pfx_ext, brk: pfx_brk};
                    pfx_ext = 1'b0; pfx_brk = 1'b0;
                end
            end else if ((pfx_ext || pfx_brk) && cyc == deadline) begin
                m_bad = 1'b1; pfx_ext = 1'b0; pfx_brk = 1'b0;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_got) begin
                m_prev = m_last;
                m_last = m_ev.code;
                if (m_sz < DEPTH || m_pop) mq.push_back(m_ev);
                else m_ovf = 1'b1;
            end
            if (m_bad && m_err < 255) m_err++;
            if (clr) begin
                m_err = 0; m_ovf = 1'b0;
            end
        end
    end

    // Compare process: every falling edge out of reset
    always @(negedge clk_50) begin
        if (rst_n) begin
            check("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
            check("fifo_level", 32'(fifo_level), 32'(mq.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
            check("last_code", 32'(last_code), 32'(m_last));
            check("prev_code", 32'(prev_code), 32'(m_prev));
            if (mq.size() != 0) begin
                check("ev_code", 32'(ev_code), 32'(mq[0].code));
                check("ev_ext", 32'(ev_ext), 32'(mq[0].ext));
                check("ev_break", 32'(ev_break), 32'(mq[0].brk));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b, input logic e);
        rx_valid = 1'b1; rx_data = b; rx_err = e;
        @(negedge clk_50);
        rx_valid = 1'b0; rx_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk_50);
        clr = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] code, input logic ext, input logic brk);
        check("head_valid", 32'(ev_valid), 32'd1);
        check("head_code", 32'(ev_code), 32'(code));
        check("head_ext", 32'(ev_ext), 32'(ext));
        check("head_brk", 32'(ev_break), 32'(brk));
        ev_ready = 1'b1;
        @(negedge clk_50);
        ev_ready = 1'b0;
    endtask

    initial begin
        idle(3);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_head", 32'({ev_code, ev_ext, ev_break}), 32'd0);
        check("rst_codes", 32'({last_code, prev_code, 7'd0, overflow}), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // make and extended make, one-cycle latency
        send(8'h1C, 1'b0);
        check("lat_valid", 32'(ev_valid), 32'd1);
        send(8'hE0, 1'b0);
        send(8'h74, 1'b0);
        check("last_74", 32'(last_code), 32'h74);
        check("prev_1c", 32'(prev_code), 32'h1C);
        pop_expect(8'h1C, 1'b0, 1'b0);
        pop_expect(8'h74, 1'b1, 1'b0);

        // break and extended break
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h74, 1'b0);
        pop_expect(8'h1C, 1'b0, 1'b1);
        pop_expect(8'h74, 1'b1, 1'b1);
        check("brk_err0", 32'(err_cnt), 32'd0);

        // overflow, then push+pop on a full FIFO
        send(8'h1C, 1'b0); send(8'h1B, 1'b0); send(8'h23, 1'b0);
        send(8'h2B, 1'b0); send(8'h34, 1'b0);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_last", 32'(last_code), 32'h34);
        pulse_clr();
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd4);
        ev_ready = 1'b1;
        send(8'h33, 1'b0);
        ev_ready = 1'b0;
        check("full_pp_level", 32'(fifo_level), 32'd4);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        pop_expect(8'h1B, 1'b0, 1'b0);
        pop_expect(8'h23, 1'b0, 1'b0);
        pop_expect(8'h2B, 1'b0, 1'b0);
        pop_expect(8'h33, 1'b0, 1'b0);

        // device responses and line error
        send(8'hAA, 1'b0); send(8'hFA, 1'b0);
        check("resp_level", 32'(fifo_level), 32'd0);
        check("resp_err", 32'(err_cnt), 32'd0);
        send(8'hE0, 1'b0); send(8'h1C, 1'b1);
        check("rxerr_level", 32'(fifo_level), 32'd0);
        check("rxerr_cnt", 32'(err_cnt), 32'd1);
        send(8'h1C, 1'b0);
        pop_expect(8'h1C, 1'b0, 1'b0);

        // timeout, double prefixes, byte on the timeout cycle
        pulse_clr();
        send(8'hE0, 1'b0);
        idle(TMO + 2);
        check("tmo_err", 32'(err_cnt), 32'd1);
        send(8'h74, 1'b0);
        pop_expect(8'h74, 1'b0, 1'b0);
        send(8'hE0, 1'b0); send(8'hE0, 1'b0);
        check("e0e0_err", 32'(err_cnt), 32'd2);
        send(8'hF0, 1'b0); send(8'hF0, 1'b0);
        check("f0f0_err", 32'(err_cnt), 32'd3);
        send(8'hE0, 1'b0);
        idle(TMO - 1);
        send(8'h74, 1'b0);
        check("tmo_edge_err", 32'(err_cnt), 32'd3);
        pop_expect(8'h74, 1'b1, 1'b0);

        // reset mid-event with events queued
        send(8'h1C, 1'b0); send(8'h1B, 1'b0); send(8'hF0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ev_valid), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_err", 32'(err_cnt), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h1C, 1'b0);
        pop_expect(8'h1C, 1'b0, 1'b0);

        // clr leaves queued events alone
        send(8'h1C, 1'b0); send(8'h1B, 1'b0);
        send(8'hE0, 1'b0); send(8'hE0, 1'b0);
        pulse_clr();
        check("clr_err", 32'(err_cnt), 32'd0);
        check("clr_keep", 32'(fifo_level), 32'd2);
        pop_expect(8'h1C, 1'b0, 1'b0);
        pop_expect(8'h1B, 1'b0, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            ev_ready = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 59) == 0) begin
                rx_valid = 1'b0;
                idle(TMO + $urandom_range(0, 3) - 2);
            end else if (!rx_valid && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 15);
                rx_valid = 1'b1;
                rx_err   = ($urandom_range(0, 29) == 0);
                if (r < 3)       rx_data = 8'hE0;
                else if (r < 6)  rx_data = 8'hF0;
                else if (r == 6) rx_data = 8'hAA;
                else if (r == 7) rx_data = 8'hFA;
                else             rx_data = 8'($urandom_range(0, 255));
            end else begin
                rx_valid = 1'b0;
                rx_err   = 1'b0;
            end
            @(negedge clk_50);
        end
        rx_valid = 1'b0; rx_err = 1'b0; clr = 1'b0;
        ev_ready = 1'b1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
